// File: rtl/display_scan.sv
// Eight-digit multiplexed seven-segment scanner with per-frame input snapshots.
// Optional whole-display flashing is enabled by defining DISPLAY_SCAN_BLINK_EN.
module display_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  input  logic       blink,
  output logic [7:0] an,
  output logic [7:0] seg
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc;
  logic [2:0]    index;
  logic [5:0]    sh [8];
  logic          tick;
  logic          frame_end;
  logic          blank;

  assign tick      = (presc == PRESC_LAST);
  assign frame_end = tick && (index == 3'd7);

  function automatic logic [6:0] pat(input logic [5:0] code);
    logic [6:0] p;
    p = 7'h00;
    if (!code[0]) begin
      case (code[4:1])
        4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
        4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
        4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
        4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
      endcase
    end else begin
      // Letter/symbol codes; anything not listed stays blank but keeps its digit enabled
      case (code[5:1])
        5'b00001: p = 7'h06;
        5'b00010: p = 7'h5B;
        5'b00110: p = 7'h3D;
        5'b01010: p = 7'h73;
        5'b01011: p = 7'h7C;
        5'b01100: p = 7'h58;
        5'b01101: p = 7'h6D;
        5'b01110: p = 7'h79;
        5'b01111: p = 7'h3E;
        5'b11111: p = 7'h40;
        default:  p = 7'h00;
      endcase
    end
    return p;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
      index <= 3'd0;
    end else if (tick) begin
      presc <= '0;
      index <= index + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Snapshot all digits at the frame boundary so one frame never mixes old and new codes
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) sh[i] <= 6'b111111;
    end else if (frame_end) begin
      sh[0] <= d1;
      sh[1] <= d2;
      sh[2] <= d3;
      sh[3] <= d4;
      sh[4] <= d5;
      sh[5] <= d6;
      sh[6] <= d7;
      sh[7] <= d8;
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  logic [7:0] frame_cnt;
  logic       phase;

  always_ff @(posedge clock) begin
    if (reset || !blink) begin
      frame_cnt <= 8'd0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt <= 8'd0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign blank = blink && phase;
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign blank        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset || blank) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= ~(8'b1 << index);
      seg <= {1'b1, ~pat(sh[index])};
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: cycle-count reference model checked every cycle, plus directed
// literal checks. Blink expectations follow DISPLAY_SCAN_BLINK_EN when it is defined.
module tb_display_scan;

  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FRAME = 8 * RD;

  logic       clock;
  logic       reset;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       blink;
  logic [7:0] an;
  logic [7:0] seg;

  int checks = 0;
  int passes = 0;

  display_scan #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clock(clock), .reset(reset),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .blink(blink), .an(an), .seg(seg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] refPat(input logic [5:0] code);
    logic [6:0] hexTab [16];
    hexTab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    if (!code[0]) return hexTab[code[4:1]];
    case (code[5:1])
      5'b00001: return 7'h06;
      5'b00010: return 7'h5B;
      5'b00110: return 7'h3D;
      5'b01010: return 7'h73;
      5'b01011: return 7'h7C;
      5'b01100: return 7'h58;
      5'b01101: return 7'h6D;
      5'b01110: return 7'h79;
      5'b01111: return 7'h3E;
      5'b11111: return 7'h40;
      default:  return 7'h00;
    endcase
  endfunction

  // Reference model: position in the scan follows from cycles elapsed since reset
  int         cyc = 0;
  int         framesDone = 0;
  logic [5:0] snap [8];
  logic [7:0] expAn, expSeg;
  bit         modelValid = 0;

  always @(posedge clock) begin
    int  idx;
    bit  blankNow;
    if (reset) begin
      cyc = 0;
      framesDone = 0;
      for (int i = 0; i < 8; i++) snap[i] = 6'b111111;
      expAn = 8'hFF;
      expSeg = 8'hFF;
      modelValid = 1;
    end else if (modelValid) begin
      idx = (cyc / RD) % 8;
`ifdef DISPLAY_SCAN_BLINK_EN
      blankNow = blink && (((framesDone / BF) % 2) == 1);
`else
      blankNow = 0;
`endif
      expAn  = blankNow ? 8'hFF : ~(8'd1 << idx);
      expSeg = blankNow ? 8'hFF : {1'b1, ~refPat(snap[idx])};
      if ((cyc % FRAME) == FRAME - 1) begin
        snap = '{d1, d2, d3, d4, d5, d6, d7, d8};
        if (blink) framesDone++;
      end
      if (!blink) framesDone = 0;
      cyc++;
    end
  end

  always @(negedge clock) begin
    if (modelValid) begin
      checks++;
      if (an === expAn && seg === expSeg) passes++;
      else $display("[TB] FAIL model cyc=%0d: got an=%h seg=%h, expected an=%h seg=%h",
                    cyc, an, seg, expAn, expSeg);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] wantAn, input logic [7:0] wantSeg);
    checks++;
    if (an === wantAn && seg === wantSeg) passes++;
    else $display("[TB] FAIL %s: got an=%h seg=%h, expected an=%h seg=%h",
                  name, an, seg, wantAn, wantSeg);
  endtask

  task automatic advanceTo(input int target);
    int guard = 0;
    while (cyc != target && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != target) begin
      checks++;
      $display("[TB] FAIL advance_timeout: got cyc=%0d, expected cyc=%0d", cyc, target);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] v1, v2, v3, v4, v5, v6, v7, v8);
    {d1, d2, d3, d4, d5, d6, d7, d8} = {v1, v2, v3, v4, v5, v6, v7, v8};
  endtask

  initial begin
    logic [7:0] frameSeg [8];
    frameSeg = '{8'hC1, 8'h92, 8'hBF, 8'hF9, 8'h8C, 8'hBF, 8'hBF, 8'hBF};
    reset = 1'b1;
    blink = 1'b0;
    applyStimulus(6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
    repeat (3) @(negedge clock);
    checkOutput("reset_state", 8'hFF, 8'hFF);
    reset = 1'b0;

    advanceTo(1);
    checkOutput("first_edge", 8'hFE, 8'hBF);
    advanceTo(5);
    checkOutput("second_digit", 8'hFD, 8'hBF);

    applyStimulus(6'b011111, 6'b011011, 6'h3F, 6'b000011, 6'b010101, 6'h3F, 6'h3F, 6'h3F);
    for (int j = 0; j < 8; j++) begin
      advanceTo(FRAME + 1 + 4 * j);
      checkOutput($sformatf("frame1_digit%0d", j + 1), ~(8'd1 << j), frameSeg[j]);
    end

    applyStimulus(6'b100001, 6'b000110, 6'h3F, 6'b000011, 6'b000000, 6'h3F, 6'h3F, 6'h3F);
    advanceTo(2 * FRAME + 1);
    checkOutput("undefined_blank", 8'hFE, 8'hFF);
    advanceTo(2 * FRAME + 5);
    checkOutput("hex_3", 8'hFD, 8'hB0);
    advanceTo(2 * FRAME + 9);
    checkOutput("d3_before_change", 8'hFB, 8'hBF);
    advanceTo(2 * FRAME + 17);
    checkOutput("hex_0", 8'hEF, 8'hC0);

    d3 = 6'b001101;
    d7 = 6'b000011;
    advanceTo(2 * FRAME + 25);
    checkOutput("d7_held_midframe", 8'hBF, 8'hBF);
    advanceTo(3 * FRAME + 9);
    checkOutput("d3_shows_G", 8'hFB, 8'hC2);
    advanceTo(3 * FRAME + 25);
    checkOutput("d7_shows_1", 8'hBF, 8'hF9);

    advanceTo(4 * FRAME + 21);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_mid_frame", 8'hFF, 8'hFF);
    reset = 1'b0;
    blink = 1'b1;
    @(negedge clock);
    checkOutput("post_reset_first", 8'hFE, 8'hBF);
    advanceTo(5);
    checkOutput("post_reset_no_reload", 8'hFD, 8'hBF);
    advanceTo(FRAME + 1);
    checkOutput("post_reset_reload_d1", 8'hFE, 8'hFF);
    advanceTo(FRAME + 5);
    checkOutput("post_reset_reload_d2", 8'hFD, 8'hB0);
    advanceTo(2 * FRAME + 5);
`ifdef DISPLAY_SCAN_BLINK_EN
    checkOutput("blink_dark_frame", 8'hFF, 8'hFF);
`else
    checkOutput("blink_ignored", 8'hFD, 8'hB0);
`endif
    advanceTo(5 * FRAME);
    blink = 1'b0;
    advanceTo(6 * FRAME + 8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000; clock cycles each digit is held before the scan advances (legal range 2 to 2^20).
REQ-002 Parameter BLINK_FRAMES, default 64; full scan frames per blink half-period (legal range 1 to 255).
REQ-003 clock  in  1  system clock; every register changes only on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 d1..d8  in  6 each  display symbol codes from the game FSM; d1 is the rightmost digit.
REQ-006 blink  in  1  level request to flash the whole display, driven from p1_win | p2_win.
REQ-007 an  out  8  digit enables, active-low; an[k] drives digit d(k+1).
REQ-008 seg  out  8  cathodes, active-low; seg[7]=dp, seg[6:0]=gfedcba.

Function
REQ-009 The prescaler shall count 0..REFRESH_DIV-1 and wrap; the wrap cycle is the tick.
REQ-010 On each tick, the 3-bit index shall advance by 1, wrapping from 7 to 0.
REQ-011 Shadow registers sh[0..7] shall load d1..d8 only on a tick where index==7, so every frame shows one coherent snapshot.
REQ-012 Outputs shall be registered with 1-cycle latency: an <= ~(8'b1 << index); seg <= {1'b1, ~pat(sh[index])}.
REQ-013 Exactly one an bit shall be low in every cycle after the first post-reset edge; dp shall always be off (seg[7]=1).
REQ-014 A code with bit0=0 shall decode as the hex digit in bits[4:1] (gfedcba hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-015 A code with bit0=1 shall decode by bits[5:1]: 00001 '1'=06, 00010 '2'=5B, 00110 G=3D, 01010 P=73, 01011 b=7C, 01100 c=58, 01101 S=6D, 01110 E=79, 01111 U=3E, 11111 '-'=40.
REQ-016 Any other bit0=1 code shall decode as blank (pat=00, seg=8'hFF), with its digit still enabled.
REQ-017 Input changes between shadow loads shall not affect seg.
REQ-018 A frame counter shall increment on each tick with index==7, wrap at BLINK_FRAMES-1, and toggle a phase bit on wrap.

Reset
REQ-019 While reset is high: prescaler=0, index=0, frame counter=0, phase=0, every sh=6'b111111, an=8'hFF, seg=8'hFF.
REQ-020 On the first edge after reset is released: an=8'hFE and seg=8'hBF (d1 shows '-').
REQ-021 Reset asserted mid-frame shall take effect on that edge and discard the partial frame; the next frame shall start at index 0.

Configuration
REQ-022 With macro DISPLAY_SCAN_BLINK_EN defined: while blink=1 and phase=1, an shall be forced to 8'hFF and seg to 8'hFF. Scanning, shadow loads and counters shall continue unchanged. When blink=0, phase shall be cleared to 0 and the frame counter held at 0.
REQ-023 Without DISPLAY_SCAN_BLINK_EN: blink shall be ignored, and the frame counter and phase logic shall be absent.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-024 Reset release, d1..d8=6'b111111 -> an steps FE,FD,FB,...,7F, each held 4 cycles, then repeats at FE; seg=8'hBF throughout.
REQ-025 d1=011111, d2=011011, d4=000011, d5=010101, others 111111, applied before the first index-7 tick -> following frame shows seg C1,92,BF,F9,8C,BF,BF,BF on an FE,FD,FB,F7,EF,DF,BF,7F.
REQ-026 d2=6'b000110 (digit 3) and d5=6'b000000 (digit 0) -> digit 2 seg=8'hB0, digit 5 seg=8'hC0; d1=6'b100001 (undefined) -> digit 1 seg=8'hFF with an[0] low.
REQ-027 d3 changed from '-' to G while index=4 -> seg for digit 3 stays 8'hBF for the rest of that frame and becomes 8'hC2 in the next frame.
REQ-028 Macro defined, blink=1 -> 2 frames normal, 2 frames with an=8'hFF and seg=8'hFF, repeating; blink=0 -> normal scan resumes on the next cycle. Macro undefined -> blink has no effect.
REQ-029 Reset pulsed at index=5 -> next cycle an=8'hFF, seg=8'hFF; after release an=8'hFE, with sh reloaded only at the next index-7 tick.
